cdc_handshake_rx: RTL and testbench

- Destination-side responder of a 4-phase req/ack bundled-data CDC handshake. All logic runs in the clkB domain.
- The source domain drives req_async and holds data_async stable while req_async is high.
- This block synchronizes req, captures the bus, and presents it to a local consumer with valid/ready.
- It returns an ack level, which the source domain synchronizes on its own side.

---
 rtl/cdc_hs_pkg.sv | 12 +
 rtl/cdc_sync_bit.sv | 25 ++
 rtl/cdc_handshake_rx.sv | 103 ++++++++++
 tb/tb_cdc_handshake_rx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the req/ack bundled-data CDC handshake.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    VALID = 2'b01,
    ACK   = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset to 0.
// Usable for req on the destination side or for ack on the source side.
module cdc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Destination-side responder of a 4-phase req/ack bundled-data handshake.
// Synchronizes req, captures the bundled bus, hands it to a local consumer
// with valid/ready, and returns a registered ack level to the source.
module cdc_handshake_rx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clkB,
  input  logic                  rstB,
  input  logic                  req_async,
  input  logic [DATA_WIDTH-1:0] data_async,
  input  logic                  data_ready,
  input  logic                  err_clr,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic                  req_s;
  state_t                state_q;
  logic                  ack_q;
  logic                  data_valid_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  xfer_count_q;
  logic [CNT_WIDTH-1:0]  xfer_count_d;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk_i(clkB),
    .rst_i(rstB),
    .d_i  (req_async),
    .q_o  (req_s)
  );

  // Completed-transfer count wraps modulo 2^CNT_WIDTH.
  always_comb begin
    xfer_count_d = xfer_count_q + CNT_WIDTH'(1);
  end

  // Handshake FSM with registered ack/valid/data/err/count outputs.
  // err_clr is applied first so a same-cycle set in VALID overrides it.
  always_ff @(posedge clkB) begin
    if (rstB) begin
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      err_q        <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          ack_q        <= 1'b0;
          data_valid_q <= 1'b0;
          if (req_s) begin
            data_out_q   <= data_async;
            data_valid_q <= 1'b1;
            state_q      <= VALID;
          end
        end
        VALID: begin
          if (!req_s) begin
            err_q <= 1'b1;
          end
          if (data_ready) begin
            data_valid_q <= 1'b0;
            ack_q        <= 1'b1;
            xfer_count_q <= xfer_count_d;
            state_q      <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          ack_q        <= 1'b0;
          data_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign err        = err_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Self-checking bench for cdc_handshake_rx: per-scenario tasks, scoreboard
// queue of captured words pushed when the source raises req.
module tb_cdc_handshake_rx;

  logic       clkB = 1'b0;
  logic       rstB;
  logic       req_async;
  logic [7:0] data_async;
  logic       data_ready;
  logic       err_clr;
  logic       ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       err;
  logic [7:0] xfer_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_w;
  logic [7:0] exp_cnt;
  logic [7:0] last_word;
  bit         ok;

  cdc_handshake_rx #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .CNT_WIDTH  (8)
  ) dut (
    .clkB      (clkB),
    .rstB      (rstB),
    .req_async (req_async),
    .data_async(data_async),
    .data_ready(data_ready),
    .err_clr   (err_clr),
    .ack       (ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .err       (err),
    .xfer_count(xfer_count)
  );

  always #5 clkB = ~clkB;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clkB);
    #1;
  endtask

  task automatic src_raise(input logic [7:0] d);
    data_async = d;
    req_async  = 1'b1;
    sb_q.push_back(d);
    last_word = d;
  endtask

  task automatic pop_exp(output logic [7:0] w);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got empty queue required one entry");
      w = 8'hxx;
    end else begin
      w = sb_q.pop_front();
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (data_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_ack(input logic lvl, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ack === lvl) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rstB = 1'b1; req_async = 1'b0; data_async = 8'h00;
    data_ready = 1'b0; err_clr = 1'b0;
    tick(); tick(); tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", ack); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", data_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", data_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (xfer_count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h required 00", xfer_count); end
    rstB = 1'b0;
    exp_cnt = 8'h00;
    tick();
  endtask

  task automatic test_basic();
    data_ready = 1'b1;
    src_raise(8'hA5);
    tick(); // edge 0
    tick(); // edge 1
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b required 0", data_valid); end
    tick(); // edge 2
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", data_valid); end
    checks++; if (data_out !== exp_w) begin errors++; $display("FAIL basic_data: got %h required %h", data_out, exp_w); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_early: got %b required 0", ack); end
    tick(); // edge 3
    exp_cnt++;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack_rise: got %b required 1", ack); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b required 0", data_valid); end
    checks++; if (xfer_count !== exp_cnt) begin errors++; $display("FAIL basic_count: got %h required %h", xfer_count, exp_cnt); end
    req_async = 1'b0;
    tick(); // edge 4
    tick(); // edge 5
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack_hold: got %b required 1", ack); end
    tick(); // edge 6
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_fall: got %b required 0", ack); end
    checks++; if (data_out !== exp_w) begin errors++; $display("FAIL basic_data_hold: got %h required %h", data_out, exp_w); end
  endtask

  task automatic test_backpressure();
    data_ready = 1'b0;
    src_raise(8'h3C);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout: got no data_valid required 1 within 20 cycles"); end
    pop_exp(exp_w);
    checks++; if (data_out !== exp_w) begin errors++; $display("FAIL bp_data: got %h required %h", data_out, exp_w); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (data_valid !== 1'b1 || data_out !== exp_w || ack !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b data=%h ack=%b required valid=1 data=%h ack=0",
                 i, data_valid, data_out, ack, exp_w);
      end
    end
    data_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bp_ack_rise: got %b required 1", ack); end
    checks++; if (xfer_count !== exp_cnt) begin errors++; $display("FAIL bp_count: got %h required %h", xfer_count, exp_cnt); end
    req_async = 1'b0;
    wait_ack(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_ack_fall_timeout: got ack=%b required 0", ack); end
  endtask

  task automatic test_early_withdraw();
    data_ready = 1'b0;
    src_raise(8'h5A);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ew_valid_timeout: got no data_valid required 1"); end
    pop_exp(exp_w);
    checks++; if (data_out !== exp_w) begin errors++; $display("FAIL ew_data: got %h required %h", data_out, exp_w); end
    req_async = 1'b0;
    tick(); // req first sampled low
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ew_err_early: got %b required 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ew_err_set: got %b required 1", err); end
    data_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ew_ack_pulse: got %b required 1", ack); end
    checks++; if (xfer_count !== exp_cnt) begin errors++; $display("FAIL ew_count: got %h required %h", xfer_count, exp_cnt); end
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ew_ack_end: got %b required 0", ack); end
    tick(); tick(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ew_err_sticky: got %b required 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ew_err_clear: got %b required 0", err); end

    // Second violation with err_clr asserted on the setting edge.
    data_ready = 1'b0;
    src_raise(8'hC3);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ew2_valid_timeout: got no data_valid required 1"); end
    pop_exp(exp_w);
    checks++; if (data_out !== exp_w) begin errors++; $display("FAIL ew2_data: got %h required %h", data_out, exp_w); end
    req_async = 1'b0;
    tick();
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ew2_err_early: got %b required 0", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ew2_set_wins: got %b required 1", err); end
    data_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ew2_ack_pulse: got %b required 1", ack); end
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ew2_ack_end: got %b required 0", ack); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ew2_err_clear: got %b required 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'hEE; words[2] = 8'h96;
    data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_raise(words[i]);
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_valid_timeout %0d: got no data_valid required 1", i); end
      pop_exp(exp_w);
      checks++; if (data_out !== exp_w) begin errors++; $display("FAIL b2b_data %0d: got %h required %h", i, data_out, exp_w); end
      wait_ack(1'b1, ok);
      exp_cnt++;
      checks++; if (!ok) begin errors++; $display("FAIL b2b_ack_timeout %0d: got ack=%b required 1", i, ack); end
      req_async = 1'b0;
      wait_ack(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_ack_fall %0d: got ack=%b required 0", i, ack); end
    end
    checks++; if (xfer_count !== exp_cnt) begin errors++; $display("FAIL b2b_count: got %h required %h", xfer_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b1;
    src_raise(8'h77);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_valid_timeout: got no data_valid required 1"); end
    pop_exp(exp_w);
    tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rm_in_ack: got %b required 1", ack); end
    rstB = 1'b1;
    tick();
    rstB = 1'b0;
    exp_cnt = 8'h00;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_ack: got %b required 0", ack); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b required 0", data_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rm_data: got %h required 00", data_out); end
    checks++; if (xfer_count !== 8'h00) begin errors++; $display("FAIL rm_count: got %h required 00", xfer_count); end
    // req is still high: expect the same word to be captured again.
    sb_q.push_back(8'h77);
    data_ready = 1'b0;
    tick();
    tick();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rm_recap_early: got %b required 0", data_valid); end
    tick();
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL rm_recap_valid: got %b required 1", data_valid); end
    checks++; if (data_out !== exp_w) begin errors++; $display("FAIL rm_recap_data: got %h required %h", data_out, exp_w); end
    data_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++; if (xfer_count !== exp_cnt) begin errors++; $display("FAIL rm_count_after: got %h required %h", xfer_count, exp_cnt); end
    req_async = 1'b0;
    wait_ack(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_ack_fall: got ack=%b required 0", ack); end
  endtask

  task automatic test_data_isolation();
    data_ready = 1'b0;
    req_async  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_async = 8'(32'h1F + i * 37);
      tick();
      checks++;
      if (data_out !== last_word || data_valid !== 1'b0) begin
        errors++;
        $display("FAIL iso cycle %0d: got data=%h valid=%b required data=%h valid=0",
                 i, data_out, data_valid, last_word);
      end
    end
  endtask

  task automatic test_counter_wrap();
    rstB = 1'b1;
    req_async = 1'b0;
    tick(); tick(); tick();
    rstB = 1'b0;
    exp_cnt = 8'h00;
    data_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      src_raise(8'(i ^ 8'h5C));
      wait_valid(ok);
      pop_exp(exp_w);
      checks++;
      if (!ok || data_out !== exp_w) begin
        errors++;
        $display("FAIL wrap_data %0d: got valid_seen=%0d data=%h required data=%h", i, ok, data_out, exp_w);
      end
      wait_ack(1'b1, ok);
      exp_cnt++;
      checks++;
      if (!ok || xfer_count !== exp_cnt) begin
        errors++;
        $display("FAIL wrap_count %0d: got ack_seen=%0d count=%h required %h", i, ok, xfer_count, exp_cnt);
      end
      req_async = 1'b0;
      wait_ack(1'b0, ok);
      if (!ok) begin
        errors++;
        $display("FAIL wrap_ack_fall %0d: got ack=%b required 0", i, ack);
      end
    end
    checks++; if (xfer_count !== 8'h00) begin errors++; $display("FAIL wrap_final: got %h required 00", xfer_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_withdraw();
    test_back_to_back();
    test_reset_mid();
    test_data_isolation();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
